// File: rtl/dp_pkg.sv
// Shared encodings for the datapath selects and ALU opcodes.
package dp_pkg;
   localparam logic [1:0] SEL_X    = 2'd0;
   localparam logic [1:0] SEL_H    = 2'd1;
   localparam logic [1:0] SEL_S    = 2'd2;
   localparam logic [1:0] SEL_ZERO = 2'd3;

   localparam logic [1:0] SELB_A = 2'd0;
   localparam logic [1:0] SELB_B = 2'd1;
   localparam logic [1:0] SELB_C = 2'd2;
   localparam logic [1:0] SELB_X = 2'd3;

   localparam logic [1:0] OP_ADD  = 2'd0;
   localparam logic [1:0] OP_MUL  = 2'd1;
   localparam logic [1:0] OP_SUB  = 2'd2;
   localparam logic [1:0] OP_PASS = 2'd3;
endpackage

// File: rtl/bloco_operativo_ula.sv
// Combinational 4-op ALU, zero latency; flags over/underflow of the truncated result.
// SATURATE_EN defined: add/mul clamp to all-ones and sub clamps to zero instead of wrapping.
module ula
   import dp_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       op,
   output logic [WIDTH-1:0] y,
   output logic             ovf
);
   logic [WIDTH:0]     sum;
   logic [WIDTH:0]     diff;
   logic [2*WIDTH-1:0] prod;

   assign sum  = {1'b0, a} + {1'b0, b};
   assign diff = {1'b0, a} - {1'b0, b};
   assign prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

   always_comb begin
      y   = a;
      ovf = 1'b0;
      case (op)
         OP_ADD: begin
            y   = sum[WIDTH-1:0];
            ovf = sum[WIDTH];
         end
         OP_MUL: begin
            y   = prod[WIDTH-1:0];
            ovf = |prod[2*WIDTH-1:WIDTH];
         end
         OP_SUB: begin
            // The extra bit of the widened difference is the borrow.
            y   = diff[WIDTH-1:0];
            ovf = diff[WIDTH];
         end
         default: begin
            y   = a;
            ovf = 1'b0;
         end
      endcase
`ifdef SATURATE_EN
      if (ovf) begin
         y = (op == OP_SUB) ? '0 : '1;
      end
`else
`endif
   end
endmodule

// File: rtl/bloco_operativo.sv
// Datapath: operand snapshot, X/H/S registers and ALU; result is registered one cycle after valid.
// Result is held with result_valid until acked; a new valid while pending overwrites it and flags overrun (SATURATE_EN selects clamping ALU).
module bloco_operativo
   import dp_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             ready,
   input  logic             valid,
   input  logic             h,
   input  logic             Reg_X,
   input  logic             Reg_H,
   input  logic             Reg_S,
   input  logic [1:0]       m0,
   input  logic [1:0]       m1,
   input  logic [1:0]       m2,
   input  logic [WIDTH-1:0] x_in,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic [WIDTH-1:0] c_in,
   output logic [WIDTH-1:0] result,
   output logic             result_valid,
   input  logic             result_ack,
   output logic             ovf,
   output logic             overrun
);
   logic [WIDTH-1:0] x_snap_q, x_snap_d, a_snap_q, a_snap_d;
   logic [WIDTH-1:0] b_snap_q, b_snap_d, c_snap_q, c_snap_d;
   logic [WIDTH-1:0] x_q, x_d, h_q, h_d, s_q, s_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             result_valid_q, result_valid_d;
   logic             ovf_q, ovf_d, overrun_q, overrun_d;

   logic [WIDTH-1:0] alu_a, alu_b, alu_y;
   logic             alu_ovf;
   logic             capture;

   assign capture = ready && start;

   always_comb begin
      alu_a = '0;
      case (m0)
         SEL_X:   alu_a = x_q;
         SEL_H:   alu_a = h_q;
         SEL_S:   alu_a = s_q;
         default: alu_a = '0;
      endcase
      alu_b = '0;
      case (m1)
         SELB_A:  alu_b = a_snap_q;
         SELB_B:  alu_b = b_snap_q;
         SELB_C:  alu_b = c_snap_q;
         default: alu_b = x_q;
      endcase
   end

   ula #(.WIDTH(WIDTH)) u_ula (
      .a   (alu_a),
      .b   (alu_b),
      .op  (m2),
      .y   (alu_y),
      .ovf (alu_ovf)
   );

   always_comb begin
      x_snap_d       = x_snap_q;
      a_snap_d       = a_snap_q;
      b_snap_d       = b_snap_q;
      c_snap_d       = c_snap_q;
      x_d            = x_q;
      h_d            = h_q;
      s_d            = s_q;
      result_d       = result_q;
      result_valid_d = result_valid_q;
      ovf_d          = ovf_q;
      overrun_d      = overrun_q;

      if (capture) begin
         x_snap_d = x_in;
         a_snap_d = a_in;
         b_snap_d = b_in;
         c_snap_d = c_in;
      end
      if (Reg_X) x_d = x_snap_q;
      if (Reg_H) h_d = h ? alu_y : a_snap_q;
      if (Reg_S) s_d = alu_y;

      // A fresh snapshot starts a new computation, so its clear wins.
      if (capture) begin
         ovf_d = 1'b0;
      end else if ((Reg_S || (Reg_H && h)) && alu_ovf) begin
         ovf_d = 1'b1;
      end

      if (valid) begin
         result_d       = s_q;
         result_valid_d = 1'b1;
         if (result_valid_q && !result_ack) overrun_d = 1'b1;
      end else if (result_valid_q && result_ack) begin
         result_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         x_snap_q       <= '0;
         a_snap_q       <= '0;
         b_snap_q       <= '0;
         c_snap_q       <= '0;
         x_q            <= '0;
         h_q            <= '0;
         s_q            <= '0;
         result_q       <= '0;
         result_valid_q <= 1'b0;
         ovf_q          <= 1'b0;
         overrun_q      <= 1'b0;
      end else begin
         x_snap_q       <= x_snap_d;
         a_snap_q       <= a_snap_d;
         b_snap_q       <= b_snap_d;
         c_snap_q       <= c_snap_d;
         x_q            <= x_d;
         h_q            <= h_d;
         s_q            <= s_d;
         result_q       <= result_d;
         result_valid_q <= result_valid_d;
         ovf_q          <= ovf_d;
         overrun_q      <= overrun_d;
      end
   end

   assign result       = result_q;
   assign result_valid = result_valid_q;
   assign ovf          = ovf_q;
   assign overrun      = overrun_q;
endmodule

// File: tb/tb_bloco_operativo.sv
// Scoreboard bench for bloco_operativo: directed vectors queue expected results, a monitor checks them.
module tb_bloco_operativo;
   localparam int WIDTH = 8;

   logic             clock = 1'b0;
   logic             reset = 1'b0;
   logic             start = 1'b0, ready = 1'b1, valid = 1'b0, h = 1'b0;
   logic             Reg_X = 1'b0, Reg_H = 1'b0, Reg_S = 1'b0;
   logic [1:0]       m0 = 2'd0, m1 = 2'd0, m2 = 2'd0;
   logic [WIDTH-1:0] x_in = '0, a_in = '0, b_in = '0, c_in = '0;
   logic [WIDTH-1:0] result;
   logic             result_valid, result_ack = 1'b0, ovf, overrun;

   typedef struct {
      logic [WIDTH-1:0] res;
      logic             ovf;
      logic             ovr;
   } exp_t;
   exp_t exp_q[$];

   int checks   = 0;
   int failures = 0;
   logic vld_seen = 1'b0;
   logic rv_prev  = 1'b0;

`ifdef SATURATE_EN
   localparam int EXP_T2 = 255;
   localparam int EXP_T6 = 0;
`else
   localparam int EXP_T2 = 44;
   localparam int EXP_T6 = 254;
`endif

   bloco_operativo #(.WIDTH(WIDTH)) dut (
      .clock(clock), .reset(reset), .start(start), .ready(ready), .valid(valid),
      .h(h), .Reg_X(Reg_X), .Reg_H(Reg_H), .Reg_S(Reg_S),
      .m0(m0), .m1(m1), .m2(m2),
      .x_in(x_in), .a_in(a_in), .b_in(b_in), .c_in(c_in),
      .result(result), .result_valid(result_valid), .result_ack(result_ack),
      .ovf(ovf), .overrun(overrun)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   always @(posedge clock) vld_seen <= valid && reset;

   always @(negedge clock) begin
      if ((result_valid === 1'b1 && !rv_prev) || vld_seen) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_output", 32'(result), 32'hFFFF_FFFF);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("sb_result", 32'(result), 32'(e.res));
            chk("sb_result_valid", 32'(result_valid), 32'd1);
            chk("sb_ovf", 32'(ovf), 32'(e.ovf));
            chk("sb_overrun", 32'(overrun), 32'(e.ovr));
         end
      end
      rv_prev = (result_valid === 1'b1);
   end

   task automatic cyc();
      @(posedge clock);
      #1;
      start = 1'b0; valid = 1'b0; result_ack = 1'b0;
      Reg_X = 1'b0; Reg_H = 1'b0; Reg_S = 1'b0; h = 1'b0;
   endtask

   task automatic capture(input logic [7:0] x, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
      x_in = x; a_in = a; b_in = b; c_in = c; start = 1'b1;
      cyc();
      x_in = 8'hA5; a_in = 8'h5A; b_in = 8'h3C; c_in = 8'hC3;
   endtask

   task automatic sel(input logic [1:0] s0, input logic [1:0] s1, input logic [1:0] s2);
      m0 = s0; m1 = s1; m2 = s2;
   endtask

   task automatic present(input logic [7:0] r, input logic o, input logic v, input logic ack);
      exp_t e;
      e.res = r; e.ovf = o; e.ovr = v;
      exp_q.push_back(e);
      valid = 1'b1; result_ack = ack;
      cyc();
   endtask

   task automatic ack_it();
      result_ack = 1'b1;
      cyc();
      @(negedge clock);
      chk("rv_cleared_after_ack", 32'(result_valid), 32'd0);
   endtask

   task automatic summary();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
   endtask

   initial begin
      #100000;
      failures++;
      $display("FAIL watchdog actual=timeout required=finish");
      summary();
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0;
      cyc(); cyc();
      @(negedge clock);
      chk("rst_result", 32'(result), 32'd0);
      chk("rst_result_valid", 32'(result_valid), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);
      chk("rst_overrun", 32'(overrun), 32'd0);
      reset = 1'b1;

      // Horner: 2*4^2 + 3*4 + 5 = 49
      capture(8'd4, 8'd2, 8'd3, 8'd5);
      Reg_X = 1'b1; cyc();
      Reg_H = 1'b1; h = 1'b0; cyc();
      sel(2'd1, 2'd3, 2'd1); Reg_H = 1'b1; h = 1'b1; cyc();
      sel(2'd1, 2'd1, 2'd0); Reg_H = 1'b1; h = 1'b1; cyc();
      sel(2'd1, 2'd3, 2'd1); Reg_S = 1'b1; cyc();
      sel(2'd2, 2'd2, 2'd0); Reg_S = 1'b1; cyc();
      present(8'd49, 1'b0, 1'b0, 1'b0);
      cyc();
      @(negedge clock);
      chk("horner_held", 32'(result_valid), 32'd1);
      ack_it();

      // 200 + 100 overflows the adder
      capture(8'd200, 8'd0, 8'd100, 8'd0);
      Reg_X = 1'b1; cyc();
      sel(2'd0, 2'd1, 2'd0); Reg_S = 1'b1; cyc();
      present(8'(EXP_T2), 1'b1, 1'b0, 1'b0);
      ack_it();

      // 3 - 5 underflows; capture must clear the sticky ovf first
      capture(8'd3, 8'd5, 8'd0, 8'd0);
      @(negedge clock);
      chk("ovf_cleared_by_capture", 32'(ovf), 32'd0);
      Reg_X = 1'b1; cyc();
      sel(2'd0, 2'd0, 2'd2); Reg_S = 1'b1; cyc();
      present(8'(EXP_T6), 1'b1, 1'b0, 1'b0);
      ack_it();

      // valid and ack on the same edge while pending: no overrun
      capture(8'd7, 8'd0, 8'd0, 8'd0);
      Reg_X = 1'b1; cyc();
      sel(2'd0, 2'd0, 2'd3); Reg_S = 1'b1; cyc();
      present(8'd7, 1'b0, 1'b0, 1'b0);
      sel(2'd0, 2'd3, 2'd0); Reg_S = 1'b1; cyc();
      present(8'd14, 1'b0, 1'b0, 1'b1);
      ack_it();

      // held result without ack, then overwrite sets overrun
      capture(8'd10, 8'd0, 8'd0, 8'd0);
      Reg_X = 1'b1; cyc();
      sel(2'd0, 2'd0, 2'd3); Reg_S = 1'b1; cyc();
      present(8'd10, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         chk("hold_result", 32'(result), 32'd10);
         chk("hold_valid", 32'(result_valid), 32'd1);
         cyc();
      end
      capture(8'd20, 8'd0, 8'd0, 8'd0);
      Reg_X = 1'b1; cyc();
      sel(2'd0, 2'd0, 2'd3); Reg_S = 1'b1; cyc();
      present(8'd20, 1'b0, 1'b1, 1'b0);

      // reset mid-sequence with H=8, then start with ready=0 is ignored
      capture(8'd4, 8'd2, 8'd0, 8'd0);
      Reg_X = 1'b1; cyc();
      Reg_H = 1'b1; h = 1'b0; cyc();
      sel(2'd1, 2'd3, 2'd1); Reg_H = 1'b1; h = 1'b1;
      reset = 1'b0;
      cyc();
      @(negedge clock);
      chk("midrst_result", 32'(result), 32'd0);
      chk("midrst_result_valid", 32'(result_valid), 32'd0);
      chk("midrst_ovf", 32'(ovf), 32'd0);
      chk("midrst_overrun", 32'(overrun), 32'd0);
      reset = 1'b1;
      ready = 1'b0; x_in = 8'd9; a_in = 8'd9; start = 1'b1;
      cyc();
      ready = 1'b1;
      sel(2'd3, 2'd0, 2'd0); Reg_S = 1'b1; cyc();
      present(8'd0, 1'b0, 1'b0, 1'b0);
      sel(2'd1, 2'd0, 2'd3); Reg_S = 1'b1; cyc();
      present(8'd0, 1'b0, 1'b0, 1'b1);
      ack_it();

      cyc(); cyc();
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      summary();
      $finish;
   end
endmodule
